fp16_mul_seq: RTL and testbench

FP16_MUL_SEQ -- requirements
Module: fp16_mul_seq

---
 rtl/fp16_pkg.sv | 38 +++
 rtl/fp16_mant_mul.sv | 46 ++++
 rtl/fp16_mul_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_fp16_mul_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared types and constants for the sequential binary16 multiplier.
// FP16_ROUND_NEAREST_EN adds the ROUND state (round-to-nearest-even);
// without it the product is truncated.
package fp16_pkg;

   localparam int EXP_W      = 5;
   localparam int FRAC_W     = 10;
   localparam int SIG_W      = FRAC_W + 1;
   localparam int PROD_W     = 2 * SIG_W;
   localparam int EXPS_W     = 7;
   localparam int MULT_STEPS = SIG_W;

   localparam logic signed [EXPS_W-1:0] BIAS     = 7'sd15;
   localparam logic signed [EXPS_W-1:0] EXP_MAX  = 7'sd31;
   localparam logic        [EXP_W-1:0]  EXP_ALL1 = 5'h1F;
   localparam logic        [15:0]       QNAN     = 16'h7E00;

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      NORM,
`ifdef FP16_ROUND_NEAREST_EN
      ROUND,
`endif
      DONE
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp16_t;

   function automatic fp16_t fp16_unpack(input logic [15:0] v);
      return fp16_t'(v);
   endfunction

endpackage

// File: rtl/fp16_mant_mul.sv
// Radix-2 shift-add multiplier for the 11-bit significands.
// load clears the accumulator and captures both operands; each step
// consumes one multiplier bit, so the product is complete after DATA_W steps.
module fp16_mant_mul
   import fp16_pkg::*;
#(
   parameter int DATA_W = SIG_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  step,
   input  logic [DATA_W-1:0]     mcand_in,
   input  logic [DATA_W-1:0]     mplier_in,
   output logic [2*DATA_W-1:0]   product
);

   logic [DATA_W-1:0] mcand_q;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W:0]   sum;

   // Partial sum: add the multiplicand when the current multiplier bit is set.
   always_comb begin
      sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
   end

   // Accumulator shifts right one bit per step; multiplier bits drain out of lo_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (load) begin
         mcand_q <= mcand_in;
         hi_q    <= '0;
         lo_q    <= mplier_in;
      end else if (step) begin
         hi_q    <= sum[DATA_W:1];
         lo_q    <= {sum[0], lo_q[DATA_W-1:1]};
      end
   end

   assign product = {hi_q, lo_q};

endmodule

// File: rtl/fp16_mul_seq.sv
// Sequential IEEE-754 binary16 multiplier: IDLE -> MULT (11 cycles) -> NORM
// [-> ROUND] -> DONE. Subnormals flush to zero; specials share the fixed latency.
// Define FP16_ROUND_NEAREST_EN for round-to-nearest-even (one extra cycle).
module fp16_mul_seq
   import fp16_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result
);

   state_t                    state_q, state_d;
   logic [3:0]                cnt_q;
   fp16_t                     opa_q, opb_q;
   logic signed [EXPS_W-1:0]  exp_q;
   logic [PROD_W-1:0]         prod;
   logic [15:0]               result_q;
   logic                      load, step, ld_result;

   logic                      res_sign;
   logic                      spec_hit;
   logic [15:0]               spec_val;
   logic [FRAC_W-1:0]         nfrac;
   logic signed [EXPS_W-1:0]  nexp;
   logic [15:0]               final_val;

   // Clamp the exponent: too large -> signed inf, too small -> signed zero.
   function automatic logic [15:0] sat_pack(input logic s,
                                            input logic signed [EXPS_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
      if (e >= EXP_MAX)
         sat_pack = {s, EXP_ALL1, {FRAC_W{1'b0}}};
      else if (e <= 7'sd0)
         sat_pack = {s, 15'h0000};
      else
         sat_pack = {s, e[EXP_W-1:0], f};
   endfunction

   // Round-to-nearest-even; returns {carry, frac}. A carry means 1.11..1 + ulp = 10.0.
   function automatic logic [FRAC_W:0] round_rne(input logic [FRAC_W-1:0] f,
                                                 input logic g,
                                                 input logic st);
      logic inc;
      inc = g & (st | f[0]);
      return {1'b0, f} + {{FRAC_W{1'b0}}, inc};
   endfunction

   assign load = (state_q == IDLE) && start;
   assign step = (state_q == MULT);

   fp16_mant_mul #(
      .DATA_W (SIG_W)
   ) u_mant_mul (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .mcand_in  ({1'b1, op_a[FRAC_W-1:0]}),
      .mplier_in ({1'b1, op_b[FRAC_W-1:0]}),
      .product   (prod)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and status outputs.
   always_comb begin
      state_d = state_q;
      busy    = (state_q != IDLE);
      done    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = MULT;
         MULT: if (cnt_q == 4'(MULT_STEPS - 1)) state_d = NORM;
`ifdef FP16_ROUND_NEAREST_EN
         NORM:  state_d = ROUND;
         ROUND: state_d = DONE;
`else
         NORM:  state_d = DONE;
`endif
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // MULT step counter, parked at zero outside MULT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 cnt_q <= '0;
      else if (state_q == MULT)  cnt_q <= cnt_q + 4'd1;
      else                       cnt_q <= '0;
   end

   // Operand capture on an accepted start; later starts are ignored until IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opa_q <= '0;
         opb_q <= '0;
      end else if (load) begin
         opa_q <= fp16_unpack(op_a);
         opb_q <= fp16_unpack(op_b);
      end
   end

   // Unbiased-sum exponent, formed in the first MULT cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         exp_q <= '0;
      else if (state_q == MULT && cnt_q == 4'd0)
         exp_q <= $signed({2'b00, opa_q.exp}) + $signed({2'b00, opb_q.exp}) - BIAS;
   end

   // Special operands: NaN and inf x zero -> canonical NaN, inf -> inf, zero/subnormal -> zero.
   always_comb begin
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      res_sign = opa_q.sign ^ opb_q.sign;
      a_zero   = (opa_q.exp == '0);
      b_zero   = (opb_q.exp == '0);
      a_inf    = (opa_q.exp == EXP_ALL1) && (opa_q.frac == '0);
      b_inf    = (opb_q.exp == EXP_ALL1) && (opb_q.frac == '0);
      a_nan    = (opa_q.exp == EXP_ALL1) && (opa_q.frac != '0);
      b_nan    = (opb_q.exp == EXP_ALL1) && (opb_q.frac != '0);
      spec_hit = 1'b1;
      spec_val = QNAN;
      if (a_nan || b_nan)
         spec_val = QNAN;
      else if (a_inf || b_inf)
         spec_val = (a_zero || b_zero) ? QNAN : {res_sign, EXP_ALL1, {FRAC_W{1'b0}}};
      else if (a_zero || b_zero)
         spec_val = {res_sign, 15'h0000};
      else
         spec_hit = 1'b0;
   end

`ifdef FP16_ROUND_NEAREST_EN
   logic                      guard, sticky;
   logic [FRAC_W-1:0]         nfrac_q;
   logic signed [EXPS_W-1:0]  nexp_q;
   logic                      guard_q, sticky_q;
   logic [FRAC_W:0]           rnd;
   logic signed [EXPS_W-1:0]  rnd_exp;

   // Normalise the 22-bit product, keeping guard and sticky for rounding.
   always_comb begin
      if (prod[PROD_W-1]) begin
         nfrac  = prod[20:11];
         nexp   = exp_q + 7'sd1;
         guard  = prod[10];
         sticky = |prod[9:0];
      end else begin
         nfrac  = prod[19:10];
         nexp   = exp_q;
         guard  = prod[9];
         sticky = |prod[8:0];
      end
   end

   // ---- NORM -> ROUND boundary ----
   // Normalised fields held for the ROUND cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nfrac_q  <= '0;
         nexp_q   <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else if (state_q == NORM) begin
         nfrac_q  <= nfrac;
         nexp_q   <= nexp;
         guard_q  <= guard;
         sticky_q <= sticky;
      end
   end

   // Round, renormalise on carry-out, then re-check overflow; underflow is decided before rounding.
   always_comb begin
      rnd     = round_rne(nfrac_q, guard_q, sticky_q);
      rnd_exp = nexp_q + $signed({{(EXPS_W-1){1'b0}}, rnd[FRAC_W]});
      if (nexp_q <= 7'sd0)
         final_val = {res_sign, 15'h0000};
      else
         final_val = sat_pack(res_sign, rnd_exp, rnd[FRAC_W-1:0]);
   end

   assign ld_result = (state_q == ROUND);
`else
   logic unused_prod_lsbs;
   assign unused_prod_lsbs = ^prod[9:0];

   // Normalise the 22-bit product and truncate to 10 fraction bits.
   always_comb begin
      if (prod[PROD_W-1]) begin
         nfrac = prod[20:11];
         nexp  = exp_q + 7'sd1;
      end else begin
         nfrac = prod[19:10];
         nexp  = exp_q;
      end
      final_val = sat_pack(res_sign, nexp, nfrac);
   end

   assign ld_result = (state_q == NORM);
`endif

   // ---- result register, loaded on entry to DONE ----
   // Result holds until the next completed operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          result_q <= '0;
      else if (ld_result) result_q <= spec_hit ? spec_val : final_val;
   end

   assign result = result_q;

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Self-checking bench for fp16_mul_seq: directed cases, start held through MULT,
// reset abort, and random operands against a plain-arithmetic reference model.
module tb_fp16_mul_seq;

`ifdef FP16_ROUND_NEAREST_EN
   localparam int          LAT      = 14;
   localparam bit          RND      = 1'b1;
   localparam logic [15:0] EXP_3E01 = 16'h4082;
`else
   localparam int          LAT      = 13;
   localparam bit          RND      = 1'b0;
   localparam logic [15:0] EXP_3E01 = 16'h4081;
`endif

   localparam logic [15:0] DIR_A [8] = '{16'h3C00, 16'h3E00, 16'hBC00, 16'h3E01,
                                         16'h7BFF, 16'h8000, 16'h7C00, 16'h7E00};
   localparam logic [15:0] DIR_B [8] = '{16'h3C00, 16'h3E00, 16'h3C00, 16'h3E01,
                                         16'h7BFF, 16'h4000, 16'h0000, 16'h3C00};
   localparam logic [15:0] DIR_R [8] = '{16'h3C00, 16'h4080, 16'hBC00, EXP_3E01,
                                         16'h7C00, 16'h8000, 16'h7E00, 16'h7E00};

   logic        clk, reset, start;
   logic [15:0] op_a, op_b;
   logic        busy, done;
   logic [15:0] result;
   int          total, bad;

   fp16_mul_seq dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Reference product from the binary16 rules using integer arithmetic.
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic s;
      int ea, eb, fa, fb, e, sh, frac;
      longint p, q, rem, half;
      bit an, bn, ai, bi, az, bz;
      s  = a[15] ^ b[15];
      ea = int'(a[14:10]);  eb = int'(b[14:10]);
      fa = int'(a[9:0]);    fb = int'(b[9:0]);
      an = (ea == 31) && (fa != 0);  bn = (eb == 31) && (fb != 0);
      ai = (ea == 31) && (fa == 0);  bi = (eb == 31) && (fb == 0);
      az = (ea == 0);                bz = (eb == 0);
      if (an || bn) return 16'h7E00;
      if (ai || bi) return (az || bz) ? 16'h7E00 : {s, 15'h7C00};
      if (az || bz) return {s, 15'h0000};
      p  = longint'(1024 + fa) * longint'(1024 + fb);
      e  = ea + eb - 15;
      sh = 10;
      if (p >= 64'd2097152) begin
         e++;
         sh = 11;
      end
      if (e <= 0) return {s, 15'h0000};
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      frac = int'(q) - 1024;
      if (RND && (rem > half || (rem == half && (frac % 2) == 1))) frac++;
      if (frac == 1024) begin
         frac = 0;
         e++;
      end
      if (e >= 31) return {s, 15'h7C00};
      return {s, 5'(e), 10'(frac)};
   endfunction

   function automatic logic [15:0] rnd_op();
      logic [15:0] v;
      int          c;
      v = 16'($urandom);
      c = $urandom_range(0, 11);
      case (c)
         0: v[14:10] = 5'h00;
         1: v[14:0]  = 15'h7C00;
         2: begin
            v[14:10] = 5'h1F;
            if (v[9:0] == 10'h000) v[9] = 1'b1;
         end
         3, 4, 5: v[14:10] = 5'(11 + $urandom_range(0, 8));
         default: ;
      endcase
      return v;
   endfunction

   // One operation: start at edge t, Done expected LAT edges later, busy throughout.
   // While k <= hold, start stays high and the operand inputs keep changing.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] want, input int hold);
      int          lat;
      logic        busy_ok;
      logic [15:0] r;
      lat     = 0;
      busy_ok = 1'b1;
      r       = '0;
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= LAT + 6 && lat == 0; k++) begin
         @(negedge clk);
         if (k > hold) start = 1'b0;
         else begin
            op_a = 16'($urandom);
            op_b = 16'($urandom);
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            r   = result;
         end
      end
      start = 1'b0;
      check({tag, "_lat"}, lat, LAT);
      check({tag, "_busy"}, {31'd0, busy_ok}, 1);
      check({tag, "_res"}, {16'd0, r}, {16'd0, want});
      @(negedge clk);
      check({tag, "_idle"}, {30'd0, busy, done}, 0);
      check({tag, "_held"}, {16'd0, result}, {16'd0, want});
   endtask

   initial begin
      int          seen;
      logic [15:0] a, b;
      total = 0;
      bad   = 0;
      reset = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #2 reset = 1'b1;
      #1;
      check("rst_busy",   {31'd0, busy},   0);
      check("rst_done",   {31'd0, done},   0);
      check("rst_result", {16'd0, result}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++)
         run_op($sformatf("dir%0d", i), DIR_A[i], DIR_B[i], DIR_R[i], 0);

      // Start held high with changing operands: only the first operation completes.
      run_op("hold", 16'h3E00, 16'h3C00, 16'h3E00, 11);
      seen = 0;
      repeat (LAT + 2) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("hold_extra_done", seen, 0);

      // Reset in MULT cycle 5 aborts the operation immediately.
      @(negedge clk);
      op_a  = 16'h3E00;
      op_b  = 16'h3E00;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort_busy",   {31'd0, busy},   0);
      check("abort_done",   {31'd0, done},   0);
      check("abort_result", {16'd0, result}, 0);
      @(negedge clk);
      reset = 1'b0;
      seen  = 0;
      repeat (LAT + 3) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("abort_no_done", seen, 0);
      run_op("after_rst", 16'h4000, 16'h4000, 16'h4400, 0);

      for (int i = 0; i < 60; i++) begin
         a = rnd_op();
         b = rnd_op();
         run_op($sformatf("rnd%0d_%h_%h", i, a, b), a, b, ref_mul(a, b), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
